jtag_bsr: RTL and testbench

Parametrised JTAG boundary-scan register: a WIDTH-bit chain of capture/shift/update cells sharing one TAP-driven control set, replacing per-bit single-cell instances in the EOC JTAG logic. It sits between the TAP controller (CAPTURE_DR/SHIFT_DR/UPDATE_DR decode) and the chip I/O or configuration nets. It also adds a safe-value clamp mode and a shift-length check that blocks a corrupted update.

---
 rtl/jtag_bsr.sv | 60 ++++++
 tb/tb_jtag_bsr.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/jtag_bsr.sv
// jtag_bsr: WIDTH-cell JTAG boundary-scan register (capture/shift/update) with clamp output mode.
// Define JTAG_BSR_LENCHK_EN to add the shift-length check that blocks short updates and flags LEN_ERR.
module jtag_bsr #(
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] SAFE_VALUE = {WIDTH{1'b0}}
) (
    input  logic             CLOCK_DR,
    input  logic             RESET,
    input  logic             CAPTURE_DR,
    input  logic             SHIFT_DR,
    input  logic             UPDATE_DR,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] NDI,
    input  logic             TDI,
    output logic [WIDTH-1:0] NDO,
    output logic             TDO,
    output logic             LEN_ERR
);
    logic [WIDTH-1:0] scan_q, scan_d, upd_q, upd_d;
    logic upd_ok;
`ifdef JTAG_BSR_LENCHK_EN
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    assign upd_ok = cnt_q == '0;
    // A failed update on the same edge as a capture still leaves the flag set.
    always_comb begin
        cnt_d = CAPTURE_DR ? '0 : SHIFT_DR ? ((cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + 1'b1) : cnt_q;
        err_d = (UPDATE_DR && !upd_ok) || (err_q && !CAPTURE_DR);
    end
    always_ff @(posedge CLOCK_DR) begin
        if (RESET) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign LEN_ERR = err_q;
`else
    assign upd_ok  = 1'b1;
    assign LEN_ERR = 1'b0;
`endif
    always_comb begin
        scan_d = CAPTURE_DR ? NDI : SHIFT_DR ? {TDI, scan_q[WIDTH-1:1]} : scan_q;
        upd_d  = (UPDATE_DR && upd_ok) ? scan_q : upd_q;
    end
    always_ff @(posedge CLOCK_DR) begin
        if (RESET) begin
            scan_q <= '0;
            upd_q  <= SAFE_VALUE;
        end else begin
            scan_q <= scan_d;
            upd_q  <= upd_d;
        end
    end
    assign NDO = (MODE == 2'b01) ? upd_q : (MODE == 2'b10) ? SAFE_VALUE : NDI;
    assign TDO = scan_q[0];
endmodule

// File: tb/tb_jtag_bsr.sv
// tb_jtag_bsr: directed plus randomized checks of jtag_bsr against a queue-based reference model.
module tb_jtag_bsr;
    localparam int W = 8;
    localparam logic [W-1:0] SAFE = 8'hA5;
`ifdef JTAG_BSR_LENCHK_EN
    localparam bit LC = 1'b1;
`else
    localparam bit LC = 1'b0;
`endif
    logic clk = 1'b0, rst, cap, sh, upd, tdi, tdo, len_err;
    logic [1:0] mode;
    logic [W-1:0] ndi, ndo;
    int total = 0, bad = 0;
    bit chk_en = 1'b0;

    jtag_bsr #(.WIDTH(W), .SAFE_VALUE(SAFE)) dut (
        .CLOCK_DR(clk), .RESET(rst), .CAPTURE_DR(cap), .SHIFT_DR(sh), .UPDATE_DR(upd),
        .MODE(mode), .NDI(ndi), .TDI(tdi), .NDO(ndo), .TDO(tdo), .LEN_ERR(len_err)
    );

    always #5 clk = ~clk;

    // Reference: scan chain as a bit queue (front = TDO), shifts counted since last capture.
    bit mq[$];
    logic [W-1:0] mupd;
    int mshifts;
    bit merr;

    function automatic logic [W-1:0] qv();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = mq[i];
        return v;
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] pre;
        if (rst) begin
            mq = {};
            for (int i = 0; i < W; i++) mq.push_back(1'b0);
            mupd = SAFE;
            mshifts = 0;
            merr = 1'b0;
        end else begin
            pre = qv();
            if (cap) merr = 1'b0;
            if (upd) begin
                if (LC && (mshifts % W) != 0) merr = 1'b1;
                else mupd = pre;
            end
            if (cap) begin
                mq = {};
                for (int i = 0; i < W; i++) mq.push_back(ndi[i]);
                mshifts = 0;
            end else if (sh) begin
                void'(mq.pop_front());
                mq.push_back(tdi);
                mshifts++;
            end
        end
    end

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ndo", ndo, (mode == 2'b01) ? mupd : (mode == 2'b10) ? SAFE : ndi);
            chk("tdo", {7'b0, tdo}, {7'b0, mq[0]});
            chk("len_err", {7'b0, len_err}, {7'b0, merr});
        end
    end

    task automatic cyc(input bit r, input bit c, input bit s, input bit u, input bit t);
        rst = r; cap = c; sh = s; upd = u; tdi = t;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) cyc(0, 0, 1, 0, v[i]);
    endtask

    initial begin
        logic [W-1:0] smp;
        logic [8:0] tdo_seq;
        smp = 8'h96;
        tdo_seq = 9'b0_1001_0110;
        mode = 2'b01; ndi = 8'h3C;
        cyc(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_ndo_m01", ndo, 8'hA5);
        chk("rst_tdo", {7'b0, tdo}, 8'h00);
        chk("rst_len", {7'b0, len_err}, 8'h00);
        mode = 2'b10; #1 chk("rst_ndo_m10", ndo, 8'hA5);
        mode = 2'b00; #1 chk("rst_ndo_m00", ndo, 8'h3C);
        mode = 2'b11; #1 chk("rst_ndo_m11", ndo, 8'h3C);
        ndi = smp;
        cyc(0, 1, 0, 0, 0);
        chk("sample_tdo0", {7'b0, tdo}, {7'b0, tdo_seq[0]});
        for (int i = 1; i <= W; i++) begin
            cyc(0, 0, 1, 0, 0);
            chk($sformatf("sample_tdo%0d", i), {7'b0, tdo}, {7'b0, tdo_seq[i]});
        end
        mode = 2'b01;
        cyc(0, 1, 0, 0, 0);
        load(8'hC3);
        cyc(0, 0, 0, 1, 0);
        chk("preload_c3", ndo, 8'hC3);
        chk("preload_len", {7'b0, len_err}, 8'h00);
        cyc(0, 1, 0, 0, 0);
        load(8'hC3);
        load(8'h0F);
        cyc(0, 0, 0, 1, 0);
        chk("preload16_0f", ndo, 8'h0F);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0);
        chk("short_ndo", ndo, LC ? 8'h0F : 8'hFC);
        chk("short_len", {7'b0, len_err}, {7'b0, LC});
        cyc(0, 1, 0, 0, 0);
        chk("cap_clr_len", {7'b0, len_err}, 8'h00);
        load(8'h5A);
        cyc(0, 0, 1, 1, 1);
        chk("shift_upd_5a", ndo, 8'h5A);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("rst_mid_ndo", ndo, 8'h00);
        chk("rst_mid_len", {7'b0, len_err}, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            bit r, c, s, u;
            r = $urandom_range(0, 99) == 0;
            c = $urandom_range(0, 9) == 0;
            s = $urandom_range(0, 9) < 6;
            u = !c && $urandom_range(0, 7) == 0;
            mode = 2'($urandom);
            ndi = W'($urandom);
            cyc(r, c, s, u, 1'($urandom));
        end
        cyc(0, 0, 0, 0, 0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
